// File: rtl/abm_send_pkg.sv
// Shared definitions for the ABM send sequencer: FSM state encoding and result codes.
package abm_send_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_ACCEPT_TO = 2'd1;
    localparam logic [1:0] ERR_DONE_TO   = 2'd2;
    localparam logic [1:0] ERR_ABORTED   = 2'd3;

endpackage

// File: rtl/abm_watchdog.sv
// Per-phase watchdog: loadable down-counter that parks at zero and flags expiry there.
module abm_watchdog #(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          enable,
    output logic          expired
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/abm_send_seq.sv
// Sequencer that launches a counted series of ABM sends on two copy engines,
// with a per-phase watchdog, abort handling and a registered result report.
//
// state        | meaning
// ST_IDLE      | no sequence active, waiting for cmd_start
// ST_LAUNCH    | waiting for both engines idle before strobing eng_start
// ST_WAIT_BUSY | strobe issued, waiting for an engine to report busy
// ST_WAIT_IDLE | engines running, waiting for both to return idle
module abm_send_seq
    import abm_send_pkg::*;
#(
    parameter int CW = 16,
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_start,
    input  logic [CW-1:0] cmd_count,
    input  logic          cmd_abort,
    input  logic [TW-1:0] timeout_cycles,
    input  logic          idle_0,
    input  logic          idle_1,
    output logic          eng_start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err_code,
    output logic [CW-1:0] sends_done
);

    state_t        state;
    logic [CW-1:0] count_q;
    logic [TW-1:0] timeout_q;
    logic          eng_idle;
    logic          wd_on;
    logic          wd_fire;
    logic          wd_load;
    logic          wd_dec;
    logic          wd_expired;
    logic [CW-1:0] sends_next;

    assign eng_idle   = idle_0 & idle_1;
    assign wd_on      = (timeout_q != '0);
    assign wd_fire    = wd_on & wd_expired;
    assign sends_next = (sends_done == '1) ? sends_done : sends_done + CW'(1);

    // Watchdog is reloaded on entry to each wait phase and counts only while a phase is pending.
    always_comb begin
        wd_load = 1'b0;
        wd_dec  = 1'b0;
        if (!cmd_abort) begin
            case (state)
                ST_LAUNCH: begin
                    wd_load = eng_idle;
                end
                ST_WAIT_BUSY: begin
                    wd_load = !wd_fire && !eng_idle;
                    wd_dec  = !wd_fire && eng_idle;
                end
                ST_WAIT_IDLE: begin
                    wd_dec = !wd_fire && !eng_idle;
                end
                default: begin
                end
            endcase
        end
    end

    abm_watchdog #(
        .TW(TW)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .load     (wd_load),
        .load_val (timeout_q),
        .enable   (wd_dec),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            eng_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_code   <= ERR_OK;
            sends_done <= '0;
            count_q    <= '0;
            timeout_q  <= '0;
        end else begin
            eng_start <= 1'b0;
            done      <= 1'b0;
            if (state == ST_IDLE) begin
                if (cmd_start) begin
                    err_code   <= ERR_OK;
                    sends_done <= '0;
                    if (cmd_count != '0) begin
                        count_q   <= cmd_count;
                        timeout_q <= timeout_cycles;
                        state     <= ST_LAUNCH;
                        busy      <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else if (cmd_abort) begin
                // Abort outranks any completion or timeout seen on the same edge.
                state    <= ST_IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                err_code <= ERR_ABORTED;
            end else begin
                case (state)
                    ST_LAUNCH: begin
                        if (eng_idle) begin
                            eng_start <= 1'b1;
                            state     <= ST_WAIT_BUSY;
                        end
                    end
                    ST_WAIT_BUSY: begin
                        if (wd_fire) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            err_code <= ERR_ACCEPT_TO;
                        end else if (!eng_idle) begin
                            state <= ST_WAIT_IDLE;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (wd_fire) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            err_code <= ERR_DONE_TO;
                        end else if (eng_idle) begin
                            sends_done <= sends_next;
                            if (sends_next == count_q) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_LAUNCH;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
